// File: rtl/memory_arbiter.sv
// Two-requester round-robin arbiter for a single-port byte memory.
// Each grant runs a 1-4 beat read or write burst, one byte per cycle.
module memory_arbiter #(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [1:0]        len0,
  input  logic [1:0]        len1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              beat0,
  output logic              beat1,
  output logic              done0,
  output logic              done1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {StIdle, StBusy} stateT;

  stateT             stateQ, stateD;
  logic              ownerQ, ownerD;
  logic              lastGntQ, lastGntD;
  logic              weQ, weD;
  logic [ADDR_W-1:0] addrQ, addrD;
  logic [1:0]        lenQ, lenD;
  logic [1:0]        cntQ, cntD;
  logic [DATA_W-1:0] rdataQ, rdataD;
  logic [1:0]        rvalidQ, rvalidD;

  logic [1:0] gnt, beat, done;
  logic       winner;

  // On a tie the requester that was not granted last wins.
  assign winner = (req0 && req1) ? ~lastGntQ : req1;

  always_comb begin
    stateD    = stateQ;
    ownerD    = ownerQ;
    lastGntD  = lastGntQ;
    weD       = weQ;
    addrD     = addrQ;
    lenD      = lenQ;
    cntD      = cntQ;
    rdataD    = rdataQ;
    rvalidD   = 2'b00;
    gnt       = 2'b00;
    beat      = 2'b00;
    done      = 2'b00;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    unique case (stateQ)
      StIdle: begin
        if (req0 || req1) begin
          stateD   = StBusy;
          ownerD   = winner;
          lastGntD = winner;
          weD      = winner ? we1 : we0;
          addrD    = winner ? addr1 : addr0;
          lenD     = winner ? len1 : len0;
          cntD     = 2'd0;
        end
      end
      StBusy: begin
        gnt[ownerQ]  = 1'b1;
        beat[ownerQ] = 1'b1;
        mem_addr     = addrQ;
        mem_we       = weQ;
        mem_wdata    = ownerQ ? wdata1 : wdata0;
        addrD        = addrQ + ADDR_W'(1);
        cntD         = cntQ + 2'd1;
        if (!weQ) begin
          rdataD          = mem_rdata;
          rvalidD[ownerQ] = 1'b1;
        end
        if (cntQ == lenQ) begin
          done[ownerQ] = 1'b1;
          stateD       = StIdle;
          cntD         = 2'd0;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ   <= StIdle;
      ownerQ   <= 1'b0;
      lastGntQ <= 1'b1;
      weQ      <= 1'b0;
      addrQ    <= '0;
      lenQ     <= 2'd0;
      cntQ     <= 2'd0;
      rdataQ   <= '0;
      rvalidQ  <= 2'b00;
    end else begin
      stateQ   <= stateD;
      ownerQ   <= ownerD;
      lastGntQ <= lastGntD;
      weQ      <= weD;
      addrQ    <= addrD;
      lenQ     <= lenD;
      cntQ     <= cntD;
      rdataQ   <= rdataD;
      rvalidQ  <= rvalidD;
    end
  end

  assign gnt0    = gnt[0];
  assign gnt1    = gnt[1];
  assign beat0   = beat[0];
  assign beat1   = beat[1];
  assign done0   = done[0];
  assign done1   = done[1];
  assign rvalid0 = rvalidQ[0];
  assign rvalid1 = rvalidQ[1];
  assign rdata   = rdataQ;

endmodule

// File: tb/tb_memory_arbiter.sv
// Bench for memory_arbiter: random traffic against a burst-plan model,
// a vector table for a single read burst, and directed corner sequences.
module tb_memory_arbiter;
  localparam int AW    = 13;
  localparam int DW    = 8;
  localparam int MEMSZ = 8192;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0, req1, we0, we1;
  logic [AW-1:0] addr0, addr1;
  logic [1:0]    len0, len1;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, beat0, beat1, done0, done1, rvalid0, rvalid1;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;

  bit   [DW-1:0] mem    [MEMSZ];
  bit   [DW-1:0] refMem [MEMSZ];
  logic          pokeEn = 1'b0;
  logic [AW-1:0] pokeAddr = '0;
  logic [DW-1:0] pokeData = '0;

  int nChecks = 0;
  int nFail   = 0;

  memory_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .len0(len0), .len1(len1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .beat0(beat0), .beat1(beat1),
    .done0(done0), .done1(done1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Byte memory with combinational read; the bench preloads through pokes.
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (pokeEn) mem[pokeAddr] <= pokeData;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Invariants sampled every cycle, mid low phase.
  always @(negedge clk) begin
    #2;
    check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
    check("rvalid_exclusive", 32'(rvalid0 & rvalid1), 32'd0);
    check("we_only_busy", 32'(mem_we & ~(gnt0 | gnt1)), 32'd0);
  end

  function automatic logic [31:0] ctrlBus();
    return 32'({gnt1, gnt0, beat1, beat0, done1, done0, rvalid1, rvalid0, mem_we});
  endfunction

  task automatic checkQuiet(input string tag);
    check({tag, "_ctrl"}, ctrlBus(), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  task automatic clearInputs();
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; addr0 = '0; addr1 = '0;
    len0 = '0; len1 = '0; wdata0 = '0; wdata1 = '0;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b0;
    clearInputs();
    repeat (2) @(negedge clk);
    checkQuiet("reset");
    check("reset_rdata", 32'(rdata), 32'd0);
    rst = 1'b1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    pokeEn = 1'b1; pokeAddr = a; pokeData = d;
    @(negedge clk);
    pokeEn = 1'b0;
  endtask

  // Model: when idle and requested, a whole burst is planned as a list of beats.
  typedef struct {
    logic          owner;
    logic [AW-1:0] addr;
    logic          we;
    logic          last;
  } beatT;

  typedef struct {
    logic          req;
    logic          gnt;
    logic          beat;
    logic          done;
    logic          rv;
    logic [DW-1:0] rd;
    logic [AW-1:0] ma;
  } vecT;

  initial begin
    beatT          plan[$];
    beatT          b;
    logic          lastGnt, w, bwe;
    logic [1:0]    expRv, expG, expDone, blen;
    logic [DW-1:0] expRd, wd;
    logic [AW-1:0] base;
    vecT           tbl[7];
    logic [1:0]    tieExp[8];
    logic [DW-1:0] wrBytes[3];
    int            beats, dones;

    rst = 1'b1;
    clearInputs();
    doReset();

    // ---------------- Randomized traffic vs. burst-plan model ----------------
    lastGnt = 1'b1; expRv = 2'b00; expRd = '0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      req0 = ($urandom_range(0, 2) != 0); req1 = ($urandom_range(0, 2) != 0);
      we0 = 1'($urandom); we1 = 1'($urandom);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      len0 = 2'($urandom); len1 = 2'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      #1;
      if (plan.size() > 0) begin
        b = plan[0];
        expG = b.owner ? 2'b10 : 2'b01;
        expDone = b.last ? expG : 2'b00;
        check("rnd_gnt", 32'({gnt1, gnt0}), 32'(expG));
        check("rnd_beat", 32'({beat1, beat0}), 32'(expG));
        check("rnd_done", 32'({done1, done0}), 32'(expDone));
        check("rnd_mem_addr", 32'(mem_addr), 32'(b.addr));
        check("rnd_mem_we", 32'(mem_we), 32'(b.we));
        check("rnd_mem_wdata", 32'(mem_wdata), 32'(b.owner ? wdata1 : wdata0));
      end else begin
        check("rnd_idle", 32'({gnt1, gnt0, beat1, beat0, done1, done0, mem_we}), 32'd0);
        check("rnd_idle_addr", 32'(mem_addr), 32'd0);
      end
      check("rnd_rvalid", 32'({rvalid1, rvalid0}), 32'(expRv));
      check("rnd_rdata", 32'(rdata), 32'(expRd));
      // Effects of the coming rising edge.
      if (plan.size() > 0) begin
        b = plan.pop_front();
        if (b.we) begin
          refMem[b.addr] = b.owner ? wdata1 : wdata0;
          expRv = 2'b00;
        end else begin
          expRd = refMem[b.addr];
          expRv = b.owner ? 2'b10 : 2'b01;
        end
      end else begin
        expRv = 2'b00;
        if (req0 || req1) begin
          w = (req0 && req1) ? !lastGnt : req1;
          lastGnt = w;
          base = w ? addr1 : addr0;
          blen = w ? len1 : len0;
          bwe  = w ? we1 : we0;
          for (int i = 0; i <= int'(blen); i++) begin
            b.owner = w; b.addr = AW'(int'(base) + i); b.we = bwe; b.last = (i == int'(blen));
            plan.push_back(b);
          end
        end
      end
    end

    // ---------------- Single read burst, vector table ----------------
    doReset();
    poke(13'h0010, 8'hA1); poke(13'h0011, 8'hB2); poke(13'h0012, 8'hC3); poke(13'h0013, 8'hD4);
    tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 13'h0000};
    tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 13'h0010};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA1, 13'h0011};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hB2, 13'h0012};
    tbl[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8'hC3, 13'h0013};
    tbl[5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hD4, 13'h0000};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hD4, 13'h0000};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req0 = tbl[i].req; we0 = 1'b0; addr0 = 13'h0010; len0 = 2'd3;
      #1;
      check("tbl_gnt0", 32'(gnt0), 32'(tbl[i].gnt));
      check("tbl_beat0", 32'(beat0), 32'(tbl[i].beat));
      check("tbl_done0", 32'(done0), 32'(tbl[i].done));
      check("tbl_rvalid0", 32'(rvalid0), 32'(tbl[i].rv));
      check("tbl_rdata", 32'(rdata), 32'(tbl[i].rd));
      check("tbl_mem_addr", 32'(mem_addr), 32'(tbl[i].ma));
      check("tbl_other", 32'({gnt1, beat1, done1, rvalid1, mem_we}), 32'd0);
    end

    // ---------------- Tie from reset: grants 0,1,0,1 with idle gaps ----------------
    doReset();
    tieExp[0] = 2'b00; tieExp[1] = 2'b01; tieExp[2] = 2'b00; tieExp[3] = 2'b10;
    tieExp[4] = 2'b00; tieExp[5] = 2'b01; tieExp[6] = 2'b00; tieExp[7] = 2'b10;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      req0 = 1'b1; req1 = 1'b1; len0 = 2'd0; len1 = 2'd0;
      #1;
      check("tie_gnt", 32'({gnt1, gnt0}), 32'(tieExp[i]));
    end
    clearInputs();

    // ---------------- Write with address wrap, then readback ----------------
    doReset();
    wrBytes[0] = 8'h11; wrBytes[1] = 8'h22; wrBytes[2] = 8'h33;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b1; addr1 = 13'h1FFE; len1 = 2'd2;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      req1 = 1'b0; wdata1 = wrBytes[i];
      #1;
      check("wr_mem_addr", 32'(mem_addr), 32'(AW'(13'h1FFE + i)));
      check("wr_mem_we", 32'(mem_we), 32'd1);
      check("wr_mem_wdata", 32'(mem_wdata), 32'(wrBytes[i]));
      check("wr_done1", 32'(done1), 32'(i == 2));
      check("wr_rvalid1", 32'(rvalid1), 32'd0);
    end
    @(negedge clk);
    #1;
    check("wr_mem_1ffe", 32'(mem[13'h1FFE]), 32'h11);
    check("wr_mem_1fff", 32'(mem[13'h1FFF]), 32'h22);
    check("wr_mem_0000", 32'(mem[13'h0000]), 32'h33);
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 13'h1FFE; len1 = 2'd2;
    @(negedge clk);
    req1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      check("rb_rvalid1", 32'(rvalid1), 32'd1);
      check("rb_rdata", 32'(rdata), 32'(wrBytes[i]));
    end

    // ---------------- Reset on the 2nd beat of a 4-byte write ----------------
    doReset();
    for (int i = 0; i < 4; i++) poke(AW'(13'h0100 + i), 8'hEE);
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0100; len0 = 2'd3;
    @(negedge clk);
    req0 = 1'b0; wdata0 = 8'h55;
    @(negedge clk);
    wdata0 = 8'h66;
    #1;
    check("rstmid_we_before", 32'(mem_we), 32'd1);
    rst = 1'b0;
    #1;
    check("rstmid_we_now", 32'(mem_we), 32'd0);
    checkQuiet("rstmid_in_reset");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1;
      checkQuiet("rstmid_after");
      check("rstmid_rdata", 32'(rdata), 32'd0);
    end
    check("rstmid_mem_0100", 32'(mem[13'h0100]), 32'h55);
    check("rstmid_mem_0101", 32'(mem[13'h0101]), 32'hEE);
    clearInputs();

    // ---------------- Request dropped after grant ----------------
    doReset();
    @(negedge clk);
    req0 = 1'b1; we0 = 1'b0; addr0 = 13'h0040; len0 = 2'd3;
    beats = 0; dones = 0;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      req0 = 1'b0;
      #1;
      beats += int'(beat0);
      dones += int'(done0);
    end
    check("drop_beats", 32'(beats), 32'd4);
    check("drop_dones", 32'(dones), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, 13, memory address width; DATA_W, 8, memory data width.
REQ-002 Ports SHALL be as follows; requester n is 0 or 1, and per-requester ports carry suffix n:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- reqn  in  1  access request.
- wen  in  1  1 = write burst, 0 = read burst.
- addrn  in  ADDR_W  burst base address.
- lenn  in  2  burst length minus one (1-4 bytes).
- wdatan  in  DATA_W  write byte, presented per beat.
- gntn  out  1  requester n owns memory.
- beatn  out  1  one byte transferred this cycle.
- donen  out  1  last beat of burst this cycle.
- rvalidn  out  1  rdata holds a byte for requester n.
- rdata  out  DATA_W  registered read byte, shared.
- mem_addr  out  ADDR_W  to memory address.
- mem_wdata  out  DATA_W  to memory write data.
- mem_we  out  1  to memory write enable.
- mem_rdata  in  DATA_W  from memory; combinational read of mem_addr.

Function
REQ-003 FSM SHALL have states IDLE and BUSY.
REQ-004 IDLE, no reqn high: stay in IDLE; all gnt/beat/done/mem_we SHALL be 0.
REQ-005 IDLE, any reqn high at a rising edge: select a winner, latch its we, addr and len, set owner, and enter BUSY on that edge.
REQ-006 Arbitration SHALL be round-robin: a lone requester wins; when both request, the one not granted last wins.
REQ-007 The last-grant register SHALL reset to 1, so requester 0 wins the first tie.
REQ-008 In BUSY, gnt(owner) SHALL be 1 and the other gnt 0.
REQ-009 In BUSY, beat(owner) SHALL be 1 every cycle, i.e. one byte per cycle.
REQ-010 In BUSY, mem_addr SHALL be the current address counter.
REQ-011 In BUSY, mem_we SHALL equal the latched we.
REQ-012 In BUSY, mem_wdata SHALL equal wdata(owner) combinationally; the requester SHALL present the next byte after each beat.
REQ-013 Outside BUSY, mem_addr and mem_wdata SHALL be 0.
REQ-014 Address counter SHALL increment by 1 per beat, modulo 2^ADDR_W: 8191 wraps to 0.
REQ-015 Beat counter SHALL count 0 to latched len; done(owner) SHALL be 1 on the beat where count equals len.
REQ-016 After the done beat the FSM SHALL return to IDLE, giving 1 idle turnaround cycle between bursts.
REQ-017 Read beats: rdata SHALL capture mem_rdata at the beat's rising edge; rvalid(owner) SHALL be 1 for the following cycle only.
REQ-018 Read latency SHALL be: req sampled at edge k -> first beat cycle k+1 -> first rdata/rvalid cycle k+2.
REQ-019 On write beats, rvalid SHALL stay 0 and rdata SHALL hold its value.
REQ-020 req, addr, len and we changes during BUSY SHALL be ignored; a burst always completes, even if req drops.
REQ-021 A requester still holding req after done SHALL be re-arbitrated in IDLE like any new request.
REQ-022 Both rvalid outputs SHALL never be 1 in the same cycle.
REQ-023 Both gnt outputs SHALL never be 1 in the same cycle.

Reset
REQ-024 rst low SHALL asynchronously force: state IDLE, all outputs 0, counters 0, last-grant 1.
REQ-025 mem_we SHALL drop to 0 immediately on rst low, so no write completes.
REQ-026 rst low mid-burst SHALL abort the burst with no done; after release the arbiter SHALL start in IDLE.

Verification
REQ-027 Single read: req0, we0=0, addr0=0x0010, len0=3, memory 0x10..0x13 = A1,B2,C3,D4 -> beat0 cycles 1-4, rdata A1..D4 with rvalid0 cycles 2-5, done0 cycle 4, gnt0 falls cycle 5.
REQ-028 Write then readback: req1 write addr1=0x1FFE, len1=2, wdata 11,22,33 -> memory 0x1FFE=11, 0x1FFF=22, 0x0000=33 (wrap); a read of the same range returns 11,22,33.
REQ-029 Tie: req0 and req1 both held continuously from reset, len=0 -> grant order 0,1,0,1, one idle cycle between grants.
REQ-030 Reset mid-burst: rst low on the 2nd beat of a 4-byte write -> mem_we 0 in the same cycle; only the 1st byte written; no done; after release, IDLE with all outputs 0.
REQ-031 Req drop: req0 deasserted after grant with len0=3 -> 4 beats still occur, done0 asserted.
REQ-032 Invariant checks SHALL hold throughout all scenarios: gnt0 and gnt1 never both 1; mem_we only in BUSY.
